// File: rtl/uart_tx_param.sv
// Parametrised UART serializer: valid/ready start handshake, internal baud divider,
// configurable length/parity/stop bits latched at accept, fully registered outputs.
module uart_tx_param #(
  parameter int DATA_MAX     = 9,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                tx_clk,
  input  logic                rst,
  input  logic                tx_start,
  output logic                tx_ready,
  input  logic [DATA_MAX-1:0] tx_data,
  input  logic [3:0]          length,
  input  logic                parity_en,
  input  logic                parity_type,
  input  logic                stop2,
  output logic                tx,
  output logic                tx_busy,
  output logic                tx_done,
  output logic                tx_err
);

  localparam int CNT_W = $clog2(DATA_MAX + 1);
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LEN_MIN = 4'd5;
  localparam logic [3:0] LEN_MAX = 4'(DATA_MAX);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_MAX-1:0]   shreg_q, shreg_d;
  logic [3:0]            len_q;
  logic                  par_en_q, par_bit_q, stop2_q;
  logic                  tx_d, busy_d, done_d, err_d;
  logic                  accept, len_ok, load;
  logic                  bit_last, data_last;
  logic [DATA_MAX-1:0]   data_mask;
  logic                  par_calc;

  assign accept    = tx_start && tx_ready;
  assign len_ok    = (length >= LEN_MIN) && (length <= LEN_MAX);
  assign bit_last  = (div_q == DIV_LAST);
  assign data_last = (4'(bit_cnt_q) == (len_q - 4'd1));

  // Parity is computed from the live inputs so it can be latched with the frame.
  always_comb begin
    data_mask = '0;
    for (int i = 0; i < DATA_MAX; i++) begin
      data_mask[i] = (4'(i) < length);
    end
    par_calc = (^(tx_data & data_mask)) ^ parity_type;
  end

  // NOTE: every combinational output gets a default first so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    load      = 1'b0;
    err_d     = 1'b0;
    div_d     = (state_q == IDLE || bit_last) ? '0 : div_q + DIV_W'(1);

    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (accept) begin
          if (len_ok) begin
            state_d = START;
            shreg_d = tx_data;
            load    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      START: if (bit_last) state_d = DATA;
      DATA: begin
        if (bit_last) begin
          if (data_last) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            shreg_d   = shreg_q >> 1;
          end
        end
      end
      PARITY: if (bit_last) state_d = STOP1;
      STOP1:  if (bit_last) state_d = stop2_q ? STOP2 : IDLE;
      STOP2:  if (bit_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line value is decoded from the next state and registered, so tx never glitches.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    done_d = (state_q != IDLE) && (state_d == IDLE);
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_bit_q;
      default: tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      len_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_ready  <= 1'b1;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      if (load) begin
        len_q     <= length;
        par_en_q  <= parity_en;
        par_bit_q <= par_calc;
        stop2_q   <= stop2;
      end
      tx        <= tx_d;
      tx_busy   <= busy_d;
      tx_ready  <= ~busy_d;
      tx_done   <= done_d;
      tx_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: two instances (4 and 2 clocks per bit) share stimulus;
// every cycle of each frame is compared against hand-computed bit patterns.
module tb_uart_tx_param;

  logic       tx_clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [8:0] tx_data;
  logic [3:0] length;
  logic       parity_en, parity_type, stop2;
  logic       tx1, ready1, busy1, done1, err1;
  logic       tx2, ready2, busy2, done2, err2;

  int n_vec = 0;
  int n_err = 0;

  always #5 tx_clk = ~tx_clk;

  uart_tx_param #(.DATA_MAX(9), .CLKS_PER_BIT(4)) u_dut (
    .tx_clk(tx_clk), .rst(rst), .tx_start(tx_start), .tx_ready(ready1),
    .tx_data(tx_data), .length(length), .parity_en(parity_en),
    .parity_type(parity_type), .stop2(stop2), .tx(tx1), .tx_busy(busy1),
    .tx_done(done1), .tx_err(err1)
  );

  uart_tx_param #(.DATA_MAX(9), .CLKS_PER_BIT(2)) u_dut2 (
    .tx_clk(tx_clk), .rst(rst), .tx_start(tx_start), .tx_ready(ready2),
    .tx_data(tx_data), .length(length), .parity_en(parity_en),
    .parity_type(parity_type), .stop2(stop2), .tx(tx2), .tx_busy(busy2),
    .tx_done(done2), .tx_err(err2)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tx_clk);
    #1;
  endtask

  function automatic logic g_tx(input bit s);    return s ? tx2 : tx1;       endfunction
  function automatic logic g_busy(input bit s);  return s ? busy2 : busy1;   endfunction
  function automatic logic g_ready(input bit s); return s ? ready2 : ready1; endfunction
  function automatic logic g_done(input bit s);  return s ? done2 : done1;   endfunction

  // Entered in the first START cycle; leaves the bench sitting in the tx_done cycle.
  // bits[i] is the i-th serial bit on the line; tx_start is dropped at cycle index drop_at.
  task automatic run_frame(input string tag, input bit s, input int nbits,
                           input logic [15:0] bits, input int cpb, input int drop_at);
    int k;
    k = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < cpb; c++) begin
        check($sformatf("%s tx bit%0d cyc%0d", tag, b, c), g_tx(s), bits[b]);
        check($sformatf("%s busy bit%0d", tag, b), g_busy(s), 1'b1);
        check($sformatf("%s ready bit%0d", tag, b), g_ready(s), 1'b0);
        check($sformatf("%s done bit%0d", tag, b), g_done(s), 1'b0);
        if (k == drop_at) tx_start = 1'b0;
        k++;
        tick();
      end
    end
    check({tag, " done pulse"}, g_done(s), 1'b1);
    check({tag, " done ready"}, g_ready(s), 1'b1);
    check({tag, " done busy"}, g_busy(s), 1'b0);
    check({tag, " done tx"}, g_tx(s), 1'b1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && !(ready1 && ready2); i++) tick();
    check("idle wait", ready1 & ready2, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tx_start = 1'b0; tx_data = '0; length = 4'd8;
    parity_en = 1'b0; parity_type = 1'b0; stop2 = 1'b0;
    #3;
    check("rst tx", tx1, 1'b1);
    check("rst ready", ready1, 1'b1);
    check("rst busy", busy1, 1'b0);
    check("rst done", done1, 1'b0);
    check("rst err", err1, 1'b0);
    check("rst tx2", tx2, 1'b1);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("idle tx", tx1, 1'b1);

    // 8N1 0xA5 at 4 clk/bit; tx_start held into the frame must be ignored.
    tx_data = 9'h0A5; length = 4'd8; tx_start = 1'b1;
    tick();
    run_frame("8N1_A5", 1'b0, 10, 16'h034A, 4, 10);
    tick();
    check("8N1 done once", done1, 1'b0);
    check("8N1 no requeue busy", busy1, 1'b0);
    check("8N1 idle tx", tx1, 1'b1);
    wait_idle();

    // 7E2 0x03 at 2 clk/bit: parity 0, 11 bits.
    tx_data = 9'h003; length = 4'd7; parity_en = 1'b1; parity_type = 1'b0; stop2 = 1'b1;
    tx_start = 1'b1;
    tick();
    run_frame("7E2_03", 1'b1, 11, 16'h0606, 2, 0);
    tick();
    check("7E2 done once", done2, 1'b0);
    wait_idle();

    // 9O1 0x1FF: nine ones, odd parity bit 0, 12 bits.
    tx_data = 9'h1FF; length = 4'd9; parity_en = 1'b1; parity_type = 1'b1; stop2 = 1'b0;
    tx_start = 1'b1;
    tick();
    run_frame("9O1_1FF", 1'b0, 12, 16'h0BFE, 4, 0);
    tick();
    wait_idle();

    // Illegal length 4 is rejected with a single tx_err cycle.
    length = 4'd4; parity_en = 1'b0; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    check("len4 err", err1, 1'b1);
    check("len4 err2", err2, 1'b1);
    check("len4 tx", tx1, 1'b1);
    check("len4 busy", busy1, 1'b0);
    check("len4 ready", ready1, 1'b1);
    tick();
    check("len4 err clear", err1, 1'b0);
    check("len4 tx still", tx1, 1'b1);
    check("len4 busy still", busy1, 1'b0);

    // Following legal 5E1 request; data bits above length are ignored (low5 = 01011).
    tx_data = 9'h1EB; length = 4'd5; parity_en = 1'b1; parity_type = 1'b0;
    tx_start = 1'b1;
    tick();
    run_frame("5E1_0B", 1'b0, 8, 16'h00D6, 4, 0);
    tick();
    wait_idle();

    // Back-to-back 5N1 0x15 then 0x0A with tx_start held; data changes mid-frame.
    parity_en = 1'b0; length = 4'd5; tx_data = 9'h015; tx_start = 1'b1;
    tick();
    tx_data = 9'h00A;
    run_frame("b2b_15", 1'b0, 7, 16'h006A, 4, -1);
    tick();
    run_frame("b2b_0A", 1'b0, 7, 16'h0054, 4, 1);
    tick();
    check("b2b done cleared", done1, 1'b0);
    check("b2b idle tx", tx1, 1'b1);
    wait_idle();

    // Reset asserted during DATA bit 3 of an all-zero frame.
    tx_data = 9'h000; length = 4'd8; tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    check("pre-rst tx low", tx1, 1'b0);
    check("pre-rst busy", busy1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst tx", tx1, 1'b1);
    check("async rst busy", busy1, 1'b0);
    check("async rst ready", ready1, 1'b1);
    check("async rst tx2", tx2, 1'b1);
    tick();
    rst = 1'b0;
    tx_data = 9'h05A; length = 4'd8; tx_start = 1'b1;
    tick();
    run_frame("post_rst_5A", 1'b0, 10, 16'h02B4, 4, 0);
    tick();
    check("post_rst done cleared", done1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
